// File: rtl/fp_pkg.sv
// fp_pkg: shared IEEE-754 binary32 field definitions, classification enum and helpers.
package fp_pkg;

    localparam int unsigned FP_W      = 32;
    localparam int unsigned FP_EXP_W  = 8;
    localparam int unsigned FP_MAN_W  = 23;
    localparam int unsigned FP_MANT_W = FP_MAN_W + 1;
    localparam int unsigned FP_BIAS   = 127;
    localparam logic [FP_EXP_W-1:0] EXP_MAX = 8'hFF;

    typedef enum logic [2:0] {
        FP_ZERO,
        FP_NORM,
        FP_DENORM,
        FP_INF,
        FP_NAN
    } fp_class_t;

    typedef struct packed {
        logic                sign;
        logic [FP_EXP_W-1:0] exp;
        logic [FP_MAN_W-1:0] man;
    } fp32_t;

    // Clamp a signed shift distance into the 0..31 range of a 5-bit shifter.
    function automatic logic [4:0] clamp_sh(input logic signed [8:0] v);
        logic [4:0] r;
        if (v < 9'sd0) begin
            r = 5'd0;
        end else if (v > 9'sd31) begin
            r = 5'd31;
        end else begin
            r = v[4:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/fp32_unpack.sv
// fp32_unpack: combinational binary32 field split and classification.
//   i_data      : fp32 word
//   o_sign_c    : sign bit
//   o_class_c   : zero / normal / denormal / inf / nan
//   o_exp_unb_c : unbiased exponent (exp - 127), signed 9 bits
//   o_mant24_c  : mantissa with the hidden one, {1, man}
module fp32_unpack
    import fp_pkg::*;
(
    input  logic [FP_W-1:0]      i_data,
    output logic                 o_sign_c,
    output fp_class_t            o_class_c,
    output logic signed [8:0]    o_exp_unb_c,
    output logic [FP_MANT_W-1:0] o_mant24_c
);

    fp32_t w_f;

    assign w_f         = fp32_t'(i_data);
    assign o_sign_c    = w_f.sign;
    assign o_exp_unb_c = 9'({1'b0, w_f.exp}) - 9'(FP_BIAS);
    assign o_mant24_c  = {1'b1, w_f.man};

    // Classify from the exponent extremes.
    always_comb begin
        o_class_c = FP_NORM;
        if (w_f.exp == '0) begin
            o_class_c = (w_f.man == '0) ? FP_ZERO : FP_DENORM;
        end else if (w_f.exp == EXP_MAX) begin
            o_class_c = (w_f.man == '0) ? FP_INF : FP_NAN;
        end
    end

endmodule

// File: rtl/fp_to_int.sv
// fp_to_int: 3-stage binary32 -> signed OUT_W-bit integer converter,
// round-to-nearest-even, saturating, valid/ready on both sides.
//   clk, rst_n             : clock, async active-low reset
//   in_valid/in_ready      : input handshake, in_data is the fp32 operand
//   out_valid/out_ready    : output handshake
//   out_data               : signed integer result
//   out_inexact/ovf/nan    : result flags (nan > ovf > inexact)
module fp_to_int
    import fp_pkg::*;
#(
    parameter int unsigned OUT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [FP_W-1:0]  in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_inexact,
    output logic             out_ovf,
    output logic             out_nan
);

    localparam int unsigned        MAG_W   = OUT_W + 1;
    localparam logic signed [8:0]  E_TOP   = 9'(OUT_W - 1);
    localparam logic signed [8:0]  E_FRAC  = 9'sd23;
    localparam logic [MAG_W-1:0]   MAG_LIM = MAG_W'(1) << (OUT_W - 1);
    localparam logic [OUT_W-1:0]   POS_MAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0]   NEG_MIN = {1'b1, {(OUT_W-1){1'b0}}};

    // Pipeline registers
    logic                   r_s1_valid;
    logic                   r_s1_sign;
    fp_class_t              r_s1_class;
    logic signed [8:0]      r_s1_exp;
    logic [FP_MANT_W-1:0]   r_s1_mant;

    logic                   r_s2_valid;
    logic                   r_s2_sign;
    logic                   r_s2_nan;
    logic                   r_s2_inf;
    logic                   r_s2_povf;
    logic [MAG_W-1:0]       r_s2_mag;
    logic                   r_s2_g;
    logic                   r_s2_s;

    logic                   r_out_valid;
    logic [OUT_W-1:0]       r_out_data;
    logic                   r_out_inexact;
    logic                   r_out_ovf;
    logic                   r_out_nan;

    // Combinational nets
    logic                   w_s1_adv;
    logic                   w_s2_adv;
    logic                   w_u_sign;
    fp_class_t              w_u_class;
    logic signed [8:0]      w_u_exp;
    logic [FP_MANT_W-1:0]   w_u_mant;

    logic [4:0]             w_lsh;
    logic [4:0]             w_rsh;
    logic [4:0]             w_rsh_m1;
    logic [MAG_W-1:0]       w_a_mag;
    logic                   w_a_g;
    logic                   w_a_s;
    logic                   w_a_povf;

    logic                   w_rnd;
    logic [MAG_W-1:0]       w_mag_r;
    logic                   w_over;
    logic [OUT_W-1:0]       w_res_data;
    logic                   w_res_ovf;
    logic                   w_res_inexact;

    // Backpressure chain: each stage may load when the stage after it frees up.
    assign w_s2_adv = !r_out_valid || out_ready;
    assign w_s1_adv = !r_s2_valid || w_s2_adv;
    assign in_ready = !r_s1_valid || w_s1_adv;

    fp32_unpack u_unpack (
        .i_data      (in_data),
        .o_sign_c    (w_u_sign),
        .o_class_c   (w_u_class),
        .o_exp_unb_c (w_u_exp),
        .o_mant24_c  (w_u_mant)
    );

    // S1: register unpacked fields.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_sign  <= 1'b0;
            r_s1_class <= FP_ZERO;
            r_s1_exp   <= '0;
            r_s1_mant  <= '0;
        end else if (in_ready) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_sign  <= w_u_sign;
                r_s1_class <= w_u_class;
                r_s1_exp   <= w_u_exp;
                r_s1_mant  <= w_u_mant;
            end
        end
    end

    // S2 align: integer magnitude plus guard and sticky of the discarded fraction.
    always_comb begin
        w_a_mag  = '0;
        w_a_g    = 1'b0;
        w_a_s    = 1'b0;
        w_a_povf = 1'b0;
        w_lsh    = clamp_sh(r_s1_exp - E_FRAC);
        w_rsh    = clamp_sh(E_FRAC - r_s1_exp);
        w_rsh_m1 = w_rsh - 5'd1;
        if (r_s1_class == FP_NAN || r_s1_class == FP_INF) begin
            w_a_mag = '0;
        end else if (r_s1_class == FP_ZERO || r_s1_class == FP_DENORM) begin
            w_a_s = (r_s1_class == FP_DENORM);
        end else if (r_s1_exp > E_TOP) begin
            w_a_povf = 1'b1;
        end else if (r_s1_exp >= E_FRAC) begin
            w_a_mag = MAG_W'({40'd0, r_s1_mant} << w_lsh);
        end else if (r_s1_exp >= 9'sd0) begin
            // w_rsh is 1..23 here, so w_rsh_m1 indexes the first discarded bit
            w_a_mag = MAG_W'(r_s1_mant >> w_rsh);
            w_a_g   = |(r_s1_mant & (24'd1 << w_rsh_m1));
            w_a_s   = |(r_s1_mant & ((24'd1 << w_rsh_m1) - 24'd1));
        end else if (r_s1_exp == -9'sd1) begin
            w_a_g = 1'b1;
            w_a_s = |r_s1_mant[FP_MAN_W-1:0];
        end else begin
            w_a_s = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_s2_sign  <= 1'b0;
            r_s2_nan   <= 1'b0;
            r_s2_inf   <= 1'b0;
            r_s2_povf  <= 1'b0;
            r_s2_mag   <= '0;
            r_s2_g     <= 1'b0;
            r_s2_s     <= 1'b0;
        end else if (w_s1_adv) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_sign <= r_s1_sign;
                r_s2_nan  <= (r_s1_class == FP_NAN);
                r_s2_inf  <= (r_s1_class == FP_INF);
                r_s2_povf <= w_a_povf;
                r_s2_mag  <= w_a_mag;
                r_s2_g    <= w_a_g;
                r_s2_s    <= w_a_s;
            end
        end
    end

    // S3 round to nearest even; the extra magnitude bit keeps the carry visible.
    assign w_rnd   = r_s2_g && (r_s2_s || r_s2_mag[0]);
    assign w_mag_r = r_s2_mag + MAG_W'(w_rnd);
    // -2^(OUT_W-1) is representable, +2^(OUT_W-1) is not.
    assign w_over  = r_s2_sign ? (w_mag_r > MAG_LIM) : (w_mag_r >= MAG_LIM);

    always_comb begin
        w_res_data    = '0;
        w_res_ovf     = 1'b0;
        w_res_inexact = 1'b0;
        if (r_s2_nan) begin
            w_res_data = '0;
        end else if (r_s2_inf || r_s2_povf || w_over) begin
            w_res_ovf  = 1'b1;
            w_res_data = r_s2_sign ? NEG_MIN : POS_MAX;
        end else begin
            w_res_inexact = r_s2_g || r_s2_s;
            w_res_data    = r_s2_sign ? OUT_W'(-w_mag_r) : w_mag_r[OUT_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid   <= 1'b0;
            r_out_data    <= '0;
            r_out_inexact <= 1'b0;
            r_out_ovf     <= 1'b0;
            r_out_nan     <= 1'b0;
        end else if (w_s2_adv) begin
            r_out_valid <= r_s2_valid;
            if (r_s2_valid) begin
                r_out_data    <= w_res_data;
                r_out_inexact <= w_res_inexact;
                r_out_ovf     <= w_res_ovf;
                r_out_nan     <= r_s2_nan;
            end
        end
    end

    assign out_valid   = r_out_valid;
    assign out_data    = r_out_data;
    assign out_inexact = r_out_inexact;
    assign out_ovf     = r_out_ovf;
    assign out_nan     = r_out_nan;

endmodule
